mm_bus_arbiter: RTL and testbench

Shares the single memory-mapped bus (data memory and peripherals) between the CPU's data port and a DMA requester. CPU accesses have priority, but a streak counter guarantees DMA forward progress. A watchdog aborts transactions the target never acknowledges. It sits between `cpu` (`addr`, `wdata`, `rdata`, `mm_re`, `mm_we`) and the memory/peripheral decode, and drives the CPU stall.

---
 rtl/mm_arb_pkg.sv | 17 +
 rtl/bus_watchdog.sv | 33 +++
 rtl/mm_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_mm_bus_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_arb_pkg.sv
// Shared types and defaults for the memory-mapped bus arbiter between the CPU
// data port and the DMA requester.
package mm_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MEM_CPU  = 3'd1,
    ST_MEM_DMA  = 3'd2,
    ST_RESP_CPU = 3'd3,
    ST_RESP_DMA = 3'd4
  } arb_state_t;

  localparam logic [15:0] ABORT_DATA_DEF = 16'hDEAD;
  localparam int unsigned MAX_STREAK_DEF = 32'd4;
  localparam int unsigned TIMEOUT_DEF    = 32'd255;

endpackage

// File: rtl/bus_watchdog.sv
// Cycle counter bounding how long a bus transaction may wait for its ack;
// expired is high during the last permitted wait cycle.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_r;

  // Counts cycles spent waiting; holds once the limit is hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && !expired) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = en && (count_r == LAST);

endmodule

// File: rtl/mm_bus_arbiter.sv
// Arbitrates the shared memory-mapped bus between the CPU data port and a DMA
// requester: CPU priority, a streak limit for DMA progress, and an ack watchdog.
module mm_bus_arbiter
  import mm_arb_pkg::*;
#(
  parameter int unsigned MAX_STREAK = MAX_STREAK_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
  parameter logic [15:0] ABORT_DATA = ABORT_DATA_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_re,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_gnt,
  output logic [15:0] dma_rdata,
  output logic        dma_rvalid,
  output logic        mem_re,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  localparam int unsigned SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  arb_state_t    state_r;
  logic [SW-1:0] streak_r;
  logic          cpu_req_s;
  logic          dma_turn_s;
  logic          in_mem_s;
  logic          wd_expired_s;
  logic          is_cpu_s;

  assign cpu_req_s  = cpu_re | cpu_we;
  assign dma_turn_s = dma_req && (streak_r == STREAK_MAX);
  assign in_mem_s   = (state_r == ST_MEM_CPU) || (state_r == ST_MEM_DMA);
  assign is_cpu_s   = (state_r == ST_MEM_CPU);
  assign cpu_stall  = cpu_req_s && (state_r != ST_RESP_CPU);

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (~in_mem_s),
    .en      (in_mem_s),
    .expired (wd_expired_s)
  );

  // Arbitration FSM with registered bus strobes, read data and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      streak_r   <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 16'h0000;
      mem_wdata  <= 16'h0000;
      cpu_rdata  <= 16'h0000;
      dma_rdata  <= 16'h0000;
      dma_gnt    <= 1'b0;
      dma_rvalid <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      dma_gnt    <= 1'b0;
      dma_rvalid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cpu_req_s && !dma_turn_s) begin
            state_r   <= ST_MEM_CPU;
            mem_re    <= ~cpu_we;
            mem_we    <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            // CPU can only win with a waiting DMA while below the limit
            streak_r  <= dma_req ? (streak_r + SW'(1)) : '0;
          end else if (dma_req) begin
            state_r   <= ST_MEM_DMA;
            dma_gnt   <= 1'b1;
            mem_re    <= ~dma_we;
            mem_we    <= dma_we;
            mem_addr  <= dma_addr;
            mem_wdata <= dma_wdata;
            streak_r  <= '0;
          end else begin
            state_r  <= ST_IDLE;
            streak_r <= '0;
          end
        end
        ST_MEM_CPU, ST_MEM_DMA: begin
          if (mem_ack) begin
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            state_r    <= is_cpu_s ? ST_RESP_CPU : ST_RESP_DMA;
            dma_rvalid <= ~is_cpu_s;
            if (mem_re && is_cpu_s) begin
              cpu_rdata <= mem_rdata;
            end else if (mem_re) begin
              dma_rdata <= mem_rdata;
            end else begin
              cpu_rdata <= cpu_rdata;
            end
          end else if (wd_expired_s) begin
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            state_r    <= is_cpu_s ? ST_RESP_CPU : ST_RESP_DMA;
            dma_rvalid <= ~is_cpu_s;
            bus_err    <= 1'b1;
            if (is_cpu_s) begin
              cpu_rdata <= ABORT_DATA;
            end else begin
              dma_rdata <= ABORT_DATA;
            end
          end else begin
            state_r <= state_r;
          end
        end
        ST_RESP_CPU, ST_RESP_DMA: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          mem_re  <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_bus_arbiter.sv
// Randomized self-checking bench for mm_bus_arbiter with a transaction-level
// bus target model and expected results derived from the arbitration rules.
module tb_mm_bus_arbiter;

  localparam int MAX_STREAK = 4;
  localparam int TIMEOUT    = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_re, cpu_we, cpu_stall;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [15:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_re, mem_we, mem_ack, bus_err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem_model [logic [15:0]];
  int tgt_wait   = 0;
  bit tgt_enable = 1'b1;
  int strobe_cnt = 0;

  mm_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Advance one cycle, then act as the bus target for the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
    if ((mem_re || mem_we) && tgt_enable) begin
      strobe_cnt++;
      if (strobe_cnt == tgt_wait + 1) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          mem_model[mem_addr] = mem_wdata;
          mem_rdata = 16'($urandom);
        end else begin
          mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 16'h0000;
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
      end
    end else begin
      if (!(mem_re || mem_we)) strobe_cnt = 0;
      // stray acks outside a transaction must be ignored
      mem_ack   = (!(mem_re || mem_we)) ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = 16'($urandom);
    end
  endtask

  task automatic cpu_access(input logic re, input logic we, input logic [15:0] addr,
                            input logic [15:0] wdata, input int limit,
                            output int stalls, output int strobes, output logic [15:0] rdata,
                            output logic f_re, output logic f_we, output logic [15:0] f_addr,
                            output logic [15:0] f_wdata, output bit stable, output bit done);
    bit seen;
    seen = 1'b0; stalls = 0; strobes = 0; rdata = 16'h0000; f_re = 1'b0; f_we = 1'b0;
    f_addr = 16'h0000; f_wdata = 16'h0000; stable = 1'b1; done = 1'b0;
    cpu_re = re; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    #1;
    for (int c = 0; c < limit; c++) begin
      if (mem_re || mem_we) begin
        strobes++;
        if (!seen) begin
          seen = 1'b1; f_re = mem_re; f_we = mem_we; f_addr = mem_addr; f_wdata = mem_wdata;
        end else if (mem_re !== f_re || mem_we !== f_we || mem_addr !== f_addr || mem_wdata !== f_wdata) begin
          stable = 1'b0;
        end
      end
      if (!cpu_stall) begin
        done = 1'b1; rdata = cpu_rdata;
        break;
      end
      stalls++;
      step();
    end
    cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_re = 1'b1; cpu_we = 1'b0; dma_req = 1'b1;
    repeat (3) step();
    checks++;
    if ({mem_re, mem_we, dma_gnt, dma_rvalid, bus_err} !== 5'b00000) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {mem_re, mem_we, dma_gnt, dma_rvalid, bus_err});
    end
    checks++;
    if (mem_addr !== 16'h0000 || mem_wdata !== 16'h0000 || cpu_rdata !== 16'h0000 || dma_rdata !== 16'h0000) begin
      errors++; $display("FAIL reset_data: got addr=%h wdata=%h crd=%h drd=%h want all 0000", mem_addr, mem_wdata, cpu_rdata, dma_rdata);
    end
    checks++;
    if (cpu_stall !== 1'b1) begin
      errors++; $display("FAIL reset_stall_req: got %b want 1", cpu_stall);
    end
    cpu_re = 1'b0; dma_req = 1'b0;
    #1;
    checks++;
    if (cpu_stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall_idle: got %b want 0", cpu_stall);
    end
    rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (mem_re !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got re=%b we=%b want 0 0", mem_re, mem_we);
    end
  endtask

  task automatic test_cpu_read();
    int st, sb, w;
    logic [15:0] rd, fa, fd, a, d;
    logic fr, fw;
    bit stb, dn;
    mem_model[16'h0040] = 16'haaaa;
    tgt_wait = 0;
    cpu_access(1'b1, 1'b0, 16'h0040, 16'($urandom), 40, st, sb, rd, fr, fw, fa, fd, stb, dn);
    checks++;
    if (!dn || st != 2) begin
      errors++; $display("FAIL read_stall: got done=%0d stall_cycles=%0d want 1 2", dn, st);
    end
    checks++;
    if (sb != 1 || fr !== 1'b1 || fw !== 1'b0 || fa !== 16'h0040) begin
      errors++; $display("FAIL read_strobe: got cycles=%0d re=%b we=%b addr=%h want 1 1 0 0040", sb, fr, fw, fa);
    end
    checks++;
    if (rd !== 16'haaaa) begin
      errors++; $display("FAIL read_data: got %h want aaaa", rd);
    end
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom); d = 16'($urandom); w = $urandom_range(0, 5);
      mem_model[a] = d; tgt_wait = w;
      cpu_access(1'b1, 1'b0, a, 16'($urandom), 40, st, sb, rd, fr, fw, fa, fd, stb, dn);
      checks++;
      if (!dn || st != 2 + w || sb != 1 + w || rd !== d || !stb || fa !== a) begin
        errors++;
        $display("FAIL rand_read%0d: got stall=%0d strobe=%0d data=%h addr=%h stable=%0d want %0d %0d %h %h 1",
                 i, st, sb, rd, fa, stb, 2 + w, 1 + w, d, a);
      end
    end
  endtask

  task automatic test_cpu_write();
    int st, sb, w;
    logic [15:0] rd, fa, fd, a, d, prev;
    logic fr, fw;
    bit stb, dn;
    prev = cpu_rdata;
    tgt_wait = 3;
    cpu_access(1'b0, 1'b1, 16'h8000, 16'h1234, 40, st, sb, rd, fr, fw, fa, fd, stb, dn);
    checks++;
    if (!dn || st != 5 || sb != 4 || !stb) begin
      errors++; $display("FAIL write_timing: got stall=%0d strobe=%0d stable=%0d want 5 4 1", st, sb, stb);
    end
    checks++;
    if (fw !== 1'b1 || fr !== 1'b0 || fa !== 16'h8000 || fd !== 16'h1234) begin
      errors++; $display("FAIL write_bus: got we=%b re=%b addr=%h data=%h want 1 0 8000 1234", fw, fr, fa, fd);
    end
    checks++;
    if (rd !== prev || mem_model[16'h8000] !== 16'h1234) begin
      errors++; $display("FAIL write_rdata: got rdata=%h mem=%h want %h 1234", rd, mem_model[16'h8000], prev);
    end
    a = 16'($urandom); d = 16'($urandom); w = $urandom_range(0, 3);
    tgt_wait = w;
    cpu_access(1'b1, 1'b1, a, d, 40, st, sb, rd, fr, fw, fa, fd, stb, dn);
    checks++;
    if (fw !== 1'b1 || fr !== 1'b0 || mem_model[a] !== d || st != 2 + w || rd !== prev) begin
      errors++; $display("FAIL re_we_is_write: got we=%b re=%b mem=%h stall=%0d rdata=%h want 1 0 %h %0d %h",
                         fw, fr, mem_model[a], st, rd, d, 2 + w, prev);
    end
  endtask

  task automatic test_streak();
    logic [15:0] owners[$];
    logic [15:0] expq[$];
    int gnts, streak, dma_left;
    bit prev, strobe;
    gnts = 0; prev = 1'b0;
    streak = 0; dma_left = 2;
    for (int k = 0; k < 11; k++) begin
      if (dma_left > 0 && streak == MAX_STREAK) begin
        expq.push_back(16'h2000); streak = 0; dma_left--;
      end else begin
        expq.push_back(16'h1000); streak = (dma_left > 0) ? streak + 1 : 0;
      end
    end
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1000;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h2000; dma_wdata = 16'($urandom);
    #1;
    for (int c = 0; c < 200; c++) begin
      strobe = mem_re || mem_we;
      if (strobe && !prev) owners.push_back(mem_addr);
      if (dma_gnt) begin
        gnts++;
        if (gnts >= 2) dma_req = 1'b0;
      end
      if (!strobe) tgt_wait = $urandom_range(0, 2);
      if (owners.size() >= 11 && !cpu_stall) break;
      prev = strobe;
      step();
    end
    cpu_re = 1'b0;
    dma_req = 1'b0;
    step();
    checks++;
    if (owners.size() != 11) begin
      errors++; $display("FAIL streak_count: got %0d grants want 11", owners.size());
    end
    for (int k = 0; k < 11 && k < owners.size(); k++) begin
      checks++;
      if (owners[k] !== expq[k]) begin
        errors++; $display("FAIL streak_order%0d: got owner addr %h want %h", k, owners[k], expq[k]);
      end
    end
    checks++;
    if (gnts != 2) begin
      errors++; $display("FAIL streak_gnt: got %0d dma_gnt pulses want 2", gnts);
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] owners[$];
    logic [15:0] a, b, d, cpu_rd, dma_rd;
    int gnts, rvs, rv_c, last_c;
    bit prev, strobe, in_dma, stable;
    gnts = 0; rvs = 0; rv_c = -1; last_c = -1; prev = 1'b0; in_dma = 1'b0; stable = 1'b1;
    cpu_rd = 16'h0000; dma_rd = 16'h0000;
    a = {8'h30, 8'($urandom)}; b = {8'h50, 8'($urandom)}; d = 16'($urandom);
    mem_model[a] = d; mem_model[b] = 16'h5a5a;
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = b;
    #1;
    for (int c = 0; c < 40; c++) begin
      strobe = mem_re || mem_we;
      if (strobe && !prev) owners.push_back(mem_addr);
      if (dma_gnt) begin
        gnts++; in_dma = 1'b1;
        dma_req = 1'b0; dma_addr = 16'($urandom); dma_we = 1'($urandom);
      end
      if (in_dma && strobe) begin
        last_c = c;
        if (mem_addr !== b || mem_re !== 1'b1) stable = 1'b0;
      end
      if (dma_rvalid) begin
        rvs++; rv_c = c; dma_rd = dma_rdata;
      end
      if (cpu_re && !cpu_stall) begin
        cpu_rd = cpu_rdata; cpu_re = 1'b0;
      end
      if (!strobe) tgt_wait = $urandom_range(0, 3);
      prev = strobe;
      step();
    end
    checks++;
    if (owners.size() != 2 || owners[0] !== a || owners[1] !== b) begin
      errors++; $display("FAIL simul_order: got %0d grants first=%h want 2 grants %h then %h",
                         owners.size(), (owners.size() > 0) ? owners[0] : 16'h0000, a, b);
    end
    checks++;
    if (cpu_rd !== d) begin
      errors++; $display("FAIL simul_cpu_data: got %h want %h", cpu_rd, d);
    end
    checks++;
    if (dma_rd !== 16'h5a5a || rvs != 1 || gnts != 1) begin
      errors++; $display("FAIL simul_dma: got data=%h rvalid=%0d gnt=%0d want 5a5a 1 1", dma_rd, rvs, gnts);
    end
    checks++;
    if (rv_c != last_c + 1 || !stable) begin
      errors++; $display("FAIL simul_dma_timing: got rvalid cycle %0d stable=%0d want %0d 1", rv_c, stable, last_c + 1);
    end
  endtask

  task automatic test_timeout();
    int st, sb, w;
    logic [15:0] rd, fa, fd, a, d;
    logic fr, fw;
    bit stb, dn;
    tgt_enable = 1'b0;
    cpu_access(1'b1, 1'b0, 16'($urandom), 16'($urandom), TIMEOUT + 40, st, sb, rd, fr, fw, fa, fd, stb, dn);
    tgt_enable = 1'b1;
    checks++;
    if (!dn || sb != TIMEOUT || st != TIMEOUT + 1) begin
      errors++; $display("FAIL timeout_timing: got done=%0d strobe=%0d stall=%0d want 1 %0d %0d", dn, sb, st, TIMEOUT, TIMEOUT + 1);
    end
    checks++;
    if (rd !== 16'hDEAD || bus_err !== 1'b1) begin
      errors++; $display("FAIL timeout_abort: got rdata=%h bus_err=%b want dead 1", rd, bus_err);
    end
    a = 16'($urandom); d = 16'($urandom); w = $urandom_range(0, 2);
    mem_model[a] = d; tgt_wait = w;
    cpu_access(1'b1, 1'b0, a, 16'($urandom), 40, st, sb, rd, fr, fw, fa, fd, stb, dn);
    checks++;
    if (!dn || rd !== d || st != 2 + w || bus_err !== 1'b1) begin
      errors++; $display("FAIL after_timeout: got data=%h stall=%0d bus_err=%b want %h %0d 1", rd, st, bus_err, d, 2 + w);
    end
  endtask

  task automatic test_reset_mid();
    int cnt, rvs, sbs, st, sb;
    logic [15:0] rd, fa, fd, a, d;
    logic fr, fw;
    bit stb, dn;
    cnt = 0; rvs = 0; sbs = 0;
    tgt_wait = 10;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'($urandom); dma_wdata = 16'($urandom);
    #1;
    for (int c = 0; c < 40; c++) begin
      if (dma_gnt) dma_req = 1'b0;
      if (mem_we) cnt++;
      if (cnt == 4) break;
      step();
    end
    dma_req = 1'b0;
    checks++;
    if (cnt != 4) begin
      errors++; $display("FAIL reset_mid_reach: got %0d write strobe cycles want 4", cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 16'h0000 || mem_wdata !== 16'h0000 || bus_err !== 1'b0) begin
      errors++; $display("FAIL reset_async: got we=%b re=%b addr=%h wdata=%h bus_err=%b want 0 0 0000 0000 0",
                         mem_we, mem_re, mem_addr, mem_wdata, bus_err);
    end
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (dma_rvalid) rvs++;
      if (mem_re || mem_we) sbs++;
    end
    checks++;
    if (rvs != 0 || sbs != 0) begin
      errors++; $display("FAIL reset_mid_idle: got rvalid=%0d strobes=%0d want 0 0", rvs, sbs);
    end
    a = 16'($urandom); d = 16'($urandom); mem_model[a] = d; tgt_wait = 0;
    cpu_access(1'b1, 1'b0, a, 16'($urandom), 40, st, sb, rd, fr, fw, fa, fd, stb, dn);
    checks++;
    if (!dn || st != 2 || rd !== d) begin
      errors++; $display("FAIL reset_mid_resume: got stall=%0d data=%h want 2 %h", st, rd, d);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0000; dma_wdata = 16'h0000;
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_streak();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
